// File: rtl/control_riesgos_pipeline.sv
// Hazard and sequencing controller for the 5-stage core: memory wait-states,
// load-use bubbles and taken-branch flushes, plus a saturating stall counter.
//
//   state  | meaning
//   CORRE  | pipeline running, no outstanding memory wait
//   ESPERA | MEM access outstanding, wait counter running toward TIMEOUT-1
module control_riesgos_pipeline #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             reloj,
    input  logic             resetHZ,
    input  logic             memread_EX,
    input  logic [4:0]       rt_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             usa_rt_ID,
    input  logic             salto_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ack,
    output logic             enablePC,
    output logic             enableIF,
    output logic             enableID,
    output logic             enableEX,
    output logic             enableMEM,
    output logic             flushIF,
    output logic             flushID,
    output logic             mem_err,
    output logic [CNT_W-1:0] cuenta_stall
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic {CORRE, ESPERA} estado_t;

    estado_t          estado_q, estado_d;
    logic [WC_W-1:0]  espera_q, espera_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] cuenta_q;

    logic timeout_hit;
    logic stall_mem;
    logic load_use;
    logic en_pc, en_if, en_id, en_ex, en_mem, fl_if, fl_id;

    assign timeout_hit = (estado_q == ESPERA) && (espera_q == WC_LAST);
    assign stall_mem   = mem_req_MEM & ~mem_ack & ~timeout_hit;
    assign load_use    = memread_EX & (rt_EX != 5'd0) &
                         ((rt_EX == rs_ID) | (usa_rt_ID & (rt_EX == rt_ID)));

    always_comb begin
        en_pc  = 1'b1;
        en_if  = 1'b1;
        en_id  = 1'b1;
        en_ex  = 1'b1;
        en_mem = 1'b1;
        fl_if  = 1'b0;
        fl_id  = 1'b0;
        if (stall_mem) begin
            en_pc  = 1'b0;
            en_if  = 1'b0;
            en_id  = 1'b0;
            en_ex  = 1'b0;
            en_mem = 1'b0;
        end else if (salto_EX) begin
            fl_if = 1'b1;
            fl_id = 1'b1;
        end else if (load_use) begin
            en_pc = 1'b0;
            en_if = 1'b0;
            fl_id = 1'b1;
        end
    end

    // Reset forces every control low immediately, independent of the clock.
    assign enablePC     = en_pc  & resetHZ;
    assign enableIF     = en_if  & resetHZ;
    assign enableID     = en_id  & resetHZ;
    assign enableEX     = en_ex  & resetHZ;
    assign enableMEM    = en_mem & resetHZ;
    assign flushIF      = fl_if  & resetHZ;
    assign flushID      = fl_id  & resetHZ;
    assign mem_err      = mem_err_q;
    assign cuenta_stall = cuenta_q;

    always_comb begin
        estado_d  = estado_q;
        espera_d  = espera_q;
        mem_err_d = timeout_hit & ~mem_ack;
        case (estado_q)
            CORRE: begin
                if (mem_req_MEM && !mem_ack) begin
                    estado_d = ESPERA;
                    espera_d = '0;
                end
            end
            ESPERA: begin
                if (mem_ack || timeout_hit) estado_d = CORRE;
                else                        espera_d = espera_q + WC_W'(1);
            end
            default: estado_d = CORRE;
        endcase
    end

    always_ff @(posedge reloj or negedge resetHZ) begin
        if (!resetHZ) begin
            estado_q  <= CORRE;
            espera_q  <= '0;
            mem_err_q <= 1'b0;
            cuenta_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            espera_q  <= espera_d;
            mem_err_q <= mem_err_d;
            if (!en_pc && (cuenta_q != '1)) cuenta_q <= cuenta_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_control_riesgos_pipeline.sv
// Bench for control_riesgos_pipeline: directed scenarios with literal
// expectations plus random traffic checked every cycle against a rule model.
module tb_control_riesgos_pipeline;

    localparam int TO = 4;
    localparam int CW = 16;

    logic          reloj = 1'b0;
    logic          resetHZ;
    logic          memread_EX;
    logic [4:0]    rt_EX, rs_ID, rt_ID;
    logic          usa_rt_ID, salto_EX, mem_req_MEM, mem_ack;
    logic          enablePC, enableIF, enableID, enableEX, enableMEM;
    logic          flushIF, flushID, mem_err;
    logic [CW-1:0] cuenta_stall;

    int checks = 0;
    int errors = 0;

    control_riesgos_pipeline #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .reloj(reloj), .resetHZ(resetHZ),
        .memread_EX(memread_EX), .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .usa_rt_ID(usa_rt_ID), .salto_EX(salto_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
        .enablePC(enablePC), .enableIF(enableIF), .enableID(enableID),
        .enableEX(enableEX), .enableMEM(enableMEM),
        .flushIF(flushIF), .flushID(flushID),
        .mem_err(mem_err), .cuenta_stall(cuenta_stall)
    );

    always #5 reloj = ~reloj;

    logic [6:0] vec;
    assign vec = {enablePC, enableIF, enableID, enableEX, enableMEM, flushIF, flushID};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Rule model: a memory access is "pending" for a number of cycles; it is
    // forcibly ended after TO frozen cycles counted from the request cycle.
    bit m_pending = 0;
    int m_waited  = 0;
    bit m_err     = 0;
    int m_cnt     = 0;

    initial begin
        forever begin
            @(negedge reloj);
            if (!resetHZ) begin
                chk("model_vec_rst", {25'd0, vec}, 32'd0);
                chk("model_cnt_rst", {16'd0, cuenta_stall}, 32'd0);
                chk("model_err_rst", {31'd0, mem_err}, 32'd0);
                m_pending = 0; m_waited = 0; m_err = 0; m_cnt = 0;
            end else begin
                bit tmo, freeze, hz;
                logic [6:0] ev;
                tmo    = m_pending && (m_waited == TO - 1);
                freeze = mem_req_MEM && !mem_ack && !tmo;
                hz     = memread_EX && rt_EX != 0 &&
                         (rt_EX == rs_ID || (usa_rt_ID && rt_EX == rt_ID));
                if (freeze)        ev = 7'b0000000;
                else if (salto_EX) ev = 7'b1111111;
                else if (hz)       ev = 7'b0011101;
                else               ev = 7'b1111100;
                chk("model_vec", {25'd0, vec}, {25'd0, ev});
                chk("model_cnt", {16'd0, cuenta_stall}, m_cnt);
                chk("model_err", {31'd0, mem_err}, {31'd0, m_err});
                m_err = tmo && !mem_ack;
                if (!ev[6] && m_cnt < 65535) m_cnt++;
                if (!m_pending) begin
                    if (mem_req_MEM && !mem_ack) begin m_pending = 1; m_waited = 0; end
                end else if (mem_ack || tmo) m_pending = 0;
                else m_waited++;
            end
        end
    end

    task automatic cyc(); @(posedge reloj); #1; endtask
    task automatic smp(); @(negedge reloj); #1; endtask

    task automatic quiet();
        memread_EX = 0; rt_EX = 0; rs_ID = 0; rt_ID = 0; usa_rt_ID = 0;
        salto_EX = 0; mem_req_MEM = 0; mem_ack = 0;
    endtask

    task automatic rnd();
        memread_EX  = ($urandom_range(1) == 1);
        rt_EX       = 5'($urandom_range(7));
        rs_ID       = 5'($urandom_range(7));
        rt_ID       = 5'($urandom_range(7));
        usa_rt_ID   = ($urandom_range(1) == 1);
        salto_EX    = ($urandom_range(6) == 0);
        mem_req_MEM = ($urandom_range(4) < 2);
        mem_ack     = ($urandom_range(3) == 0);
    endtask

    initial begin
        resetHZ = 0;
        rnd();
        repeat (3) begin cyc(); rnd(); end
        smp();
        chk("rst_vec", {25'd0, vec}, 32'd0);
        chk("rst_cnt", {16'd0, cuenta_stall}, 32'd0);

        cyc(); resetHZ = 1; quiet();
        smp(); chk("release_vec", {25'd0, vec}, 32'h7C);

        cyc(); memread_EX = 1; rt_EX = 5; rs_ID = 5;
        smp(); chk("loaduse_vec", {25'd0, vec}, 32'h1D);
        cyc(); quiet();
        smp(); chk("after_bubble_vec", {25'd0, vec}, 32'h7C);
        chk("loaduse_cnt", {16'd0, cuenta_stall}, 32'd1);

        cyc(); memread_EX = 1; rt_EX = 0; rs_ID = 0;
        smp(); chk("r0_vec", {25'd0, vec}, 32'h7C);

        cyc(); quiet(); salto_EX = 1;
        smp(); chk("branch_vec", {25'd0, vec}, 32'h7F);
        cyc(); quiet();
        smp(); chk("branch_cnt", {16'd0, cuenta_stall}, 32'd1);

        cyc(); mem_req_MEM = 1;
        smp(); chk("wait0_vec", {25'd0, vec}, 32'h00);
        cyc(); salto_EX = 1;
        smp(); chk("wait1_vec", {25'd0, vec}, 32'h00);
        cyc();
        smp(); chk("wait2_vec", {25'd0, vec}, 32'h00);
        cyc(); mem_ack = 1;
        smp(); chk("ack_vec", {25'd0, vec}, 32'h7F);
        cyc(); quiet();
        smp(); chk("ack_cnt", {16'd0, cuenta_stall}, 32'd4);

        cyc(); mem_req_MEM = 1;
        for (int i = 0; i < TO; i++) begin
            smp(); chk("tmo_frozen", {25'd0, vec}, 32'h00);
            cyc();
        end
        smp(); chk("tmo_release_vec", {25'd0, vec}, 32'h7C);
        chk("tmo_err_before", {31'd0, mem_err}, 32'd0);
        cyc(); quiet();
        smp(); chk("tmo_err_pulse", {31'd0, mem_err}, 32'd1);
        chk("tmo_cnt", {16'd0, cuenta_stall}, 32'd8);
        cyc();
        smp(); chk("tmo_err_gone", {31'd0, mem_err}, 32'd0);
        chk("tmo_corre_vec", {25'd0, vec}, 32'h7C);

        cyc(); memread_EX = 1; rt_EX = 9; rt_ID = 9; usa_rt_ID = 1;
        repeat (65540) @(posedge reloj);
        #1; smp(); chk("sat_cnt", {16'd0, cuenta_stall}, 32'd65535);
        cyc(); quiet(); mem_req_MEM = 1;
        smp(); chk("sat_hold", {16'd0, cuenta_stall}, 32'd65535);
        cyc();
        smp(); chk("espera_vec", {25'd0, vec}, 32'h00);
        cyc(); resetHZ = 0;
        #1;
        chk("midrst_vec", {25'd0, vec}, 32'h00);
        chk("midrst_cnt", {16'd0, cuenta_stall}, 32'd0);
        chk("midrst_err", {31'd0, mem_err}, 32'd0);
        cyc(); resetHZ = 1; mem_req_MEM = 1; mem_ack = 1;
        smp(); chk("post_rst_ack_vec", {25'd0, vec}, 32'h7C);

        for (int i = 0; i < 3000; i++) begin
            cyc();
            rnd();
            resetHZ = ($urandom_range(199) != 0);
        end
        cyc(); resetHZ = 1; quiet();
        smp();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
